fifo_drain_sched: RTL
=====================

Name: fifo_drain_sched

Overview:
- Fabric-side scheduler that drains the two HPS-system FIFO read ports (raw echo FIFO 0 and delay-pipe FIFO 1) into a single tagged 32-bit stream.
- Per channel visit: polls the FIFO's CSR fill level, then bursts out up to BURST_MAX words using the Avalon read/waitrequest handshake.
- Channels are served round-robin, with a fixed 2-entry output buffer for backpressure.
- Sits between soc_system's FIFO export conduits and the downstream ultrasound processing pipeline.

Parameters:
- BURST_MAX, 16, maximum words drained per channel visit (1..255).
- GAP_CYCLES, 2, idle cycles after a visit before the next poll (0..15).

Ports:
- clk_clk  in  1  system clock; all logic on rising edge
- reset_reset_n  in  1  asynchronous active-low reset
- enable  in  1  1 = scheduling runs; 0 = finish current visit, then park in IDLE
- f0_read  out  1  FIFO 0 data read strobe
- f0_readdata  in  32  FIFO 0 data, valid the cycle after an accepted read
- f0_waitrequest  in  1  FIFO 0 stall
- f0_csr_address  out  3  FIFO 0 CSR address
- f0_csr_read  out  1  FIFO 0 CSR read strobe
- f0_csr_write  out  1  always 0
- f0_csr_writedata  out  32  always 0
- f0_csr_readdata  in  32  FIFO 0 CSR data, valid the cycle after f0_csr_read
- f1_read, f1_readdata, f1_waitrequest, f1_csr_address, f1_csr_read, f1_csr_write, f1_csr_writedata, f1_csr_readdata: same as f0_* for FIFO 1
- m_valid  out  1  output word valid
- m_ready  in  1  downstream accept
- m_data  out  32  output word
- m_chan  out  1  source channel: 0 = FIFO 0, 1 = FIFO 1
- m_last  out  1  last word of the current visit's burst
- cnt0  out  16  words delivered from FIFO 0; wraps at 0xFFFF->0
- cnt1  out  16  words delivered from FIFO 1; wraps at 0xFFFF->0
- busy  out  1  state != IDLE or output buffer non-empty

Behaviour:
- Reset: all outputs 0. State IDLE, channel pointer 0, output buffer empty, counters 0.
- States: IDLE, POLL, PWAIT, DRAIN, FLUSH, GAP.
- IDLE -> POLL when enable=1.
- POLL (1 cycle): assert csr_read with csr_address=0 (fill_level) on the current channel only. -> PWAIT.
- PWAIT (1 cycle): capture csr_readdata. remaining = min(csr_readdata, BURST_MAX), 8-bit; treat fill values > BURST_MAX as BURST_MAX.
  - remaining=0: no burst; toggle the channel pointer; -> GAP.
  - remaining>0: -> DRAIN.
- DRAIN: assert read on the current channel only, while remaining>0 and (buffer occupancy + in-flight) < 2.
  - A read is accepted when read=1 and waitrequest=0: decrement remaining and set in-flight.
  - Data lands in the buffer the next cycle.
  - read is held asserted, address-stable, while waitrequest=1.
  - When remaining reaches 0 -> FLUSH.
- FLUSH: wait for in-flight to clear, then toggle the channel pointer -> GAP.
- GAP: count GAP_CYCLES, then -> POLL if enable=1, else -> IDLE. GAP_CYCLES=0 means a direct transition.
- The enable deassert check happens only in GAP/IDLE. A started burst always completes.
- Output buffer: 2-entry FIFO of {data, chan, last}.
  - m_valid = buffer non-empty.
  - Pop on m_valid && m_ready.
  - Push and pop in the same cycle are allowed; occupancy is unchanged.
  - Never overflows, guaranteed by the read-issue rule.
  - m_last=1 on the word whose read took remaining from 1 to 0.
- cnt0/cnt1 increment on each pop, according to m_chan.
- csr_address is 0 at all times. csr_write/csr_writedata are tied 0.
- Asynchronous reset mid-burst: outputs clear immediately. Any in-flight FIFO word is discarded; the upstream FIFO has already advanced, and this loss is accepted.

Test Plan:
- Fill: FIFO0=3 words (A0,A1,A2), FIFO1=0, m_ready=1, enable=1.
  -> stream A0,A1,A2 with m_chan=0; m_last only on A2; then a FIFO1 poll with no reads; cnt0=3, cnt1=0.
- Fill: FIFO0=40, FIFO1=5, BURST_MAX=16.
  -> output order: 16 from ch0, 5 from ch1, 16 from ch0, 8 from ch0 (ch1 poll returns 0 in between); cnt0=40, cnt1=5.
- Stall: f0_waitrequest held high 4 cycles on the first read.
  -> f0_read stays high throughout; exactly one word is accepted when waitrequest drops; no duplicate or lost word.
- Backpressure: m_ready=0 for 10 cycles mid-burst.
  -> at most 2 words buffered; f0_read deasserts; no data loss; sequence resumes in order once m_ready=1.
- Disable: enable drops during a 16-word burst.
  -> all 16 words delivered; block parks in IDLE after GAP; busy falls to 0 once the buffer empties.
- Reset: assert reset_reset_n=0 mid-DRAIN with 1 word buffered.
  -> m_valid=0, counters 0, all read strobes 0 in the same cycle; after release, the first poll is on ch0.

Source files
------------

// File: rtl/fifo_drain_sched.sv
`default_nettype none
// ============================================================================
// Module   : fifo_drain_sched
// Purpose  : Round-robin drain scheduler for the two HPS FIFO read ports.
//            Each visit polls the channel's CSR fill level, then bursts out
//            up to BURST_MAX words over the Avalon read/waitrequest handshake
//            into a 2-entry output buffer that emits a tagged 32-bit stream.
// Ports    : clk_clk, reset_reset_n (async, active low), enable
//            f0_* / f1_*  : FIFO data-port and CSR-port conduits
//            m_valid/m_ready/m_data/m_chan/m_last : tagged output stream
//            cnt0/cnt1    : words delivered per channel (wrap at 16 bits)
//            busy         : scheduler active or output buffer non-empty
// Revision : 1.0 - initial release
// ============================================================================
module fifo_drain_sched #(
  parameter int BURST_MAX  = 16,
  parameter int GAP_CYCLES = 2
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        enable,
  output logic        f0_read,
  input  logic [31:0] f0_readdata,
  input  logic        f0_waitrequest,
  output logic [2:0]  f0_csr_address,
  output logic        f0_csr_read,
  output logic        f0_csr_write,
  output logic [31:0] f0_csr_writedata,
  input  logic [31:0] f0_csr_readdata,
  output logic        f1_read,
  input  logic [31:0] f1_readdata,
  input  logic        f1_waitrequest,
  output logic [2:0]  f1_csr_address,
  output logic        f1_csr_read,
  output logic        f1_csr_write,
  output logic [31:0] f1_csr_writedata,
  input  logic [31:0] f1_csr_readdata,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  output logic        m_chan,
  output logic        m_last,
  output logic [15:0] cnt0,
  output logic [15:0] cnt1,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_POLL  = 3'd1,
    S_PWAIT = 3'd2,
    S_DRAIN = 3'd3,
    S_FLUSH = 3'd4,
    S_GAP   = 3'd5
  } state_t;

  localparam logic [7:0]  BURST_MAX_B = BURST_MAX[7:0];
  localparam logic [31:0] BURST_MAX_W = 32'(BURST_MAX);
  localparam int          GAP_LAST_I  = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [3:0]  GAP_LAST    = GAP_LAST_I[3:0];

  state_t      state_q, state_d;
  logic        chan_q, chan_d;
  logic [7:0]  rem_q, rem_d;
  logic [3:0]  gap_q, gap_d;
  logic        infl_q, infl_d;
  logic        infl_last_q, infl_last_d;
  logic [33:0] obuf_q [2];
  logic [33:0] obuf_d [2];
  logic        wptr_q, wptr_d;
  logic        rptr_q, rptr_d;
  logic [1:0]  count_q, count_d;
  logic [15:0] cnt0_q, cnt0_d;
  logic [15:0] cnt1_q, cnt1_d;

  logic [31:0] w_rdata;
  logic [31:0] w_csr_data;
  logic        w_waitreq;
  logic [7:0]  w_fill_clamped;
  logic        w_issue;
  logic        w_accept;
  logic        w_push;
  logic        w_pop;
  state_t      w_resume;
  state_t      w_after_visit;

  assign w_rdata    = chan_q ? f1_readdata     : f0_readdata;
  assign w_csr_data = chan_q ? f1_csr_readdata : f0_csr_readdata;
  assign w_waitreq  = chan_q ? f1_waitrequest  : f0_waitrequest;

  assign w_fill_clamped = (w_csr_data > BURST_MAX_W) ? BURST_MAX_B : w_csr_data[7:0];

  // Issue only while buffer slots plus the word in flight leave room; this
  // is what keeps the 2-entry buffer from ever overflowing. Once asserted
  // under waitrequest the sum cannot grow, so read stays stable.
  assign w_issue  = (state_q == S_DRAIN) && (rem_q != 8'd0) &&
                    (({1'b0, count_q} + {2'b00, infl_q}) < 3'd2);
  assign w_accept = w_issue && !w_waitreq;
  assign w_push   = infl_q;
  assign w_pop    = (count_q != 2'd0) && m_ready;

  assign w_resume      = enable ? S_POLL : S_IDLE;
  assign w_after_visit = (GAP_CYCLES == 0) ? w_resume : S_GAP;

  // Scheduler next-state
  always_comb begin
    state_d     = state_q;
    chan_d      = chan_q;
    rem_d       = rem_q;
    gap_d       = gap_q;
    infl_d      = w_accept;
    infl_last_d = w_accept && (rem_q == 8'd1);
    case (state_q)
      S_IDLE:  if (enable) state_d = S_POLL;
      S_POLL:  state_d = S_PWAIT;
      S_PWAIT: begin
        rem_d = w_fill_clamped;
        if (w_fill_clamped == 8'd0) begin
          chan_d  = ~chan_q;
          gap_d   = 4'd0;
          state_d = w_after_visit;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_accept) begin
          rem_d = rem_q - 8'd1;
          if (rem_q == 8'd1) state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        // Channel pointer must not move until the last word has landed,
        // since the landing word is tagged with chan_q.
        if (!infl_q) begin
          chan_d  = ~chan_q;
          gap_d   = 4'd0;
          state_d = w_after_visit;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) state_d = w_resume;
        else                   gap_d   = gap_q + 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output buffer and delivery counters
  always_comb begin
    obuf_d  = obuf_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;
    if (w_push) begin
      obuf_d[wptr_q] = {infl_last_q, chan_q, w_rdata};
      wptr_d         = ~wptr_q;
    end
    if (w_pop) begin
      rptr_d = ~rptr_q;
      if (obuf_q[rptr_q][32]) cnt1_d = cnt1_q + 16'd1;
      else                    cnt0_d = cnt0_q + 16'd1;
    end
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q     <= S_IDLE;
      chan_q      <= 1'b0;
      rem_q       <= 8'd0;
      gap_q       <= 4'd0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      obuf_q[0]   <= '0;
      obuf_q[1]   <= '0;
      wptr_q      <= 1'b0;
      rptr_q      <= 1'b0;
      count_q     <= 2'd0;
      cnt0_q      <= 16'd0;
      cnt1_q      <= 16'd0;
    end else begin
      state_q     <= state_d;
      chan_q      <= chan_d;
      rem_q       <= rem_d;
      gap_q       <= gap_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
      obuf_q      <= obuf_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      cnt0_q      <= cnt0_d;
      cnt1_q      <= cnt1_d;
    end
  end

  assign f0_read          = w_issue && !chan_q;
  assign f1_read          = w_issue &&  chan_q;
  assign f0_csr_read      = (state_q == S_POLL) && !chan_q;
  assign f1_csr_read      = (state_q == S_POLL) &&  chan_q;
  assign f0_csr_address   = 3'd0;
  assign f1_csr_address   = 3'd0;
  assign f0_csr_write     = 1'b0;
  assign f1_csr_write     = 1'b0;
  assign f0_csr_writedata = 32'd0;
  assign f1_csr_writedata = 32'd0;

  assign m_valid = (count_q != 2'd0);
  assign m_data  = obuf_q[rptr_q][31:0];
  assign m_chan  = obuf_q[rptr_q][32];
  assign m_last  = obuf_q[rptr_q][33];
  assign cnt0    = cnt0_q;
  assign cnt1    = cnt1_q;
  assign busy    = (state_q != S_IDLE) || (count_q != 2'd0);

endmodule
`default_nettype wire
